// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction commands into RV32I words,
// buffers them with their word addresses in a small FIFO and streams them out.
// Optional feature: define IMM_RANGE_CHECK_EN to drop commands whose immediate
// cannot be encoded exactly (reported through err like an illegal command).
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid && ready are both high; valid never depends on ready, and
// the producer holds its payload stable until the transfer edge.
module instr_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_kind,
  input  logic [2:0]                   cmd_funct3,
  input  logic                         cmd_funct7b5,
  input  logic [4:0]                   cmd_rd,
  input  logic [4:0]                   cmd_rs1,
  input  logic [4:0]                   cmd_rs2,
  input  logic [31:0]                  cmd_imm,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_data,
  output logic [ADDR_W-1:0]            instr_addr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] K_LOAD   = 4'd0;
  localparam logic [3:0] K_STORE  = 4'd1;
  localparam logic [3:0] K_RTYPE  = 4'd2;
  localparam logic [3:0] K_ITYPE  = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_JAL    = 4'd5;
  localparam logic [3:0] K_JALR   = 4'd6;
  localparam logic [3:0] K_LUI    = 4'd7;
  localparam logic [3:0] K_AUIPC  = 4'd8;

  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_ctr_q, addr_ctr_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        kind_ok;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        is_shift;

`ifdef IMM_RANGE_CHECK_EN
  logic imm_ok;
`endif

  assign is_shift = (cmd_funct3[1:0] == 2'b01);

  // Field packing and legality of the presented command.
  always_comb begin
    word    = 32'h0;
    kind_ok = 1'b1;
    unique case (cmd_kind)
      K_LOAD:   word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0000011};
      K_STORE:  word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], 7'b0100011};
      K_RTYPE:  word = {1'b0, cmd_funct7b5, 5'b00000, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd,
                        7'b0110011};
      K_ITYPE: begin
        if (is_shift) begin
          word = {1'b0, cmd_funct7b5, 5'b00000, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd,
                  7'b0010011};
        end else begin
          word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
        end
      end
      K_BRANCH: begin
        word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:1],
                cmd_imm[11], 7'b1100011};
        // The core only decodes BEQ/BNE/BLT/BGE.
        kind_ok = (cmd_funct3 == 3'b000) || (cmd_funct3 == 3'b001) ||
                  (cmd_funct3 == 3'b100) || (cmd_funct3 == 3'b101);
      end
      K_JAL:    word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd,
                        7'b1101111};
      K_JALR:   word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b1100111};
      K_LUI:    word = {cmd_imm[31:12], cmd_rd, 7'b0110111};
      K_AUIPC:  word = {cmd_imm[31:12], cmd_rd, 7'b0010111};
      default:  kind_ok = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be representable without truncation for its format.
  always_comb begin
    imm_ok = 1'b1;
    unique case (cmd_kind)
      K_LOAD, K_STORE, K_JALR:
        imm_ok = (&cmd_imm[31:11]) || !(|cmd_imm[31:11]);
      K_ITYPE: begin
        if (is_shift) imm_ok = !(|cmd_imm[31:5]);
        else          imm_ok = (&cmd_imm[31:11]) || !(|cmd_imm[31:11]);
      end
      K_BRANCH:
        imm_ok = ((&cmd_imm[31:12]) || !(|cmd_imm[31:12])) && !cmd_imm[0];
      K_JAL:
        imm_ok = ((&cmd_imm[31:20]) || !(|cmd_imm[31:20])) && !cmd_imm[0];
      K_LUI, K_AUIPC:
        imm_ok = !(|cmd_imm[11:0]);
      default: imm_ok = 1'b1;
    endcase
  end
  assign legal = kind_ok && imm_ok;
`else
  assign legal = kind_ok;
`endif

  // No pop bypass: a full FIFO stalls commands even if the head pops this cycle.
  assign cmd_ready = !flush && (count_q < CNT_W'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && legal;
  assign pop       = !flush && instr_ready && (count_q != '0);

  // Next-state for pointers, occupancy, address counter and sticky error.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_ctr_d = addr_ctr_q;
    err_d      = err_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      addr_ctr_d = BASE_ADDR;
      err_d      = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        addr_ctr_d = addr_ctr_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (accept && !legal) err_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_ctr_q <= BASE_ADDR;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_ctr_q <= addr_ctr_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage: word and its address are captured together on push.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= word;
      tag_q[wr_ptr_q]  <= addr_ctr_q;
    end
  end

  // When empty, show zero data and the address the next word will take.
  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? data_q[rd_ptr_q] : 32'h0;
  assign instr_addr  = instr_valid ? tag_q[rd_ptr_q] : addr_ctr_q;
  assign fifo_count  = count_q;
  assign err         = err_q;

endmodule
